fetch_pc_sequencer: RTL

//  Owns the architectural fetch PC. Issues instruction-memory requests over a req/ack handshake.

---
 rtl/fetch_pc_sequencer_if.sv | 12 +
 rtl/fetch_pc_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/fetch_pc_sequencer_if.sv
// Instruction-memory request/acknowledge channel between the fetch sequencer and IMEM.
interface fetch_pc_sequencer_if #(
  parameter int unsigned WordSize = 32
);
  logic                imem_req;
  logic [WordSize-1:0] imem_addr;
  logic                imem_ack;
  logic [WordSize-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: issues IMEM requests, applies taken-branch redirects and drains
// wrong-path requests before resuming at the target; misaligned targets halt fetch.
module fetch_pc_sequencer #(
  parameter int unsigned          WordSize   = 32,
  parameter logic [WordSize-1:0]  ResetVec   = '0,
  parameter int unsigned          InstrBytes = 4
) (
  input  logic                clk,
  input  logic                rst,
  fetch_pc_sequencer_if.master imem,
  input  logic                ex_valid,
  input  logic                branch_taken,
  input  logic [WordSize-1:0] branch_addr,
  input  logic                stall,
  output logic                if_valid,
  output logic [WordSize-1:0] if_instr,
  output logic [WordSize-1:0] if_pc,
  output logic                flush,
  output logic                misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  state_t              state_q, state_d;
  logic [WordSize-1:0] pc_q, pc_d;
  logic [WordSize-1:0] held_addr_q;
  logic                outstanding_q;
  logic                req;
  logic                deliver;
  logic                redir;
  logic                target_ok;
  logic                waiting;

  assign redir     = ex_valid & branch_taken & (state_q != HALT);
  assign target_ok = (branch_addr[1:0] == 2'b00);
  assign flush     = redir;
  assign waiting   = req & ~imem.imem_ack;

  // A request already on the bus keeps its address even after pc has moved to a redirect target.
  assign imem.imem_addr = outstanding_q ? held_addr_q : pc_q;
  assign imem.imem_req  = req;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    deliver = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redir) begin
          if (target_ok) pc_d = branch_addr;
          else           state_d = HALT;
        end
      end
      FETCH: begin
        req = outstanding_q | ~stall;
        if (redir) begin
          if (target_ok) begin
            pc_d = branch_addr;
            if (req & ~imem.imem_ack) state_d = DRAIN;
          end else begin
            state_d = HALT;
          end
        end else if (req & imem.imem_ack) begin
          pc_d    = pc_q + WordSize'(InstrBytes);
          deliver = 1'b1;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (redir & ~target_ok)  state_d = HALT;
        else if (imem.imem_ack)  state_d = FETCH;
        if (redir & target_ok)   pc_d = branch_addr;
      end
      HALT: begin
        req = outstanding_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= ResetVec;
      outstanding_q <= 1'b0;
      held_addr_q   <= '0;
      if_valid      <= 1'b0;
      if_instr      <= '0;
      if_pc         <= '0;
      misalign      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= waiting;
      if (waiting) held_addr_q <= imem.imem_addr;
      if_valid      <= deliver;
      if (deliver) begin
        if_instr <= imem.imem_rdata;
        if_pc    <= imem.imem_addr;
      end
      if (redir & ~target_ok) misalign <= 1'b1;
    end
  end

endmodule
